cavlc_blk_scheduler: RTL
========================

# cavlc_blk_scheduler

Sequences the 16 luma 4x4 blocks of each macroblock through the CAVLC counting datapath and the downstream CAVLC bitstream encoder. It gates block issue into the counter, holds the counter's result until the encoder finishes, tracks block and macroblock position, and keeps the neighbour total-coeff context needed to produce nC for each block. It sits between the quantiser output (coefficient source) and the counter/encoder pair.

## Interface
- MAX_MB_W, 120: maximum picture width in macroblocks; sizes the top-context line store.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- frame_start_i  in  1  pulse; restart at MB (0,0), sampling mb_width_i.
- mb_width_i  in  7  picture width in MBs, range 1..MAX_MB_W.
- blk_valid_i  in  1  source presents a 4x4 block on the counter's coefficient inputs.
- blk_ready_o  out  1  block accepted this cycle when high together with blk_valid_i.
- cnt_valid_o  out  1  drives the counter's valid input.
- cnt_ready_i  in  1  counter idle (cavlc_cnt_ready).
- cnt_done_i  in  1  counter results valid (cavlc_cnt_valid).
- total_coeff_i  in  5  counter total_coeff_cnt.
- cnt_hold_o  out  1  drives the counter's cavlc_enc_ready; the counter leaves its wait state when this is low.
- enc_start_o  out  1  pulse; encoder starts on the current block.
- enc_nc_o  out  5  nC for the current block, 0..16.
- enc_blk_idx_o  out  4  block index within the MB, in standard 8x8-then-4x4 order.
- enc_done_i  in  1  pulse; encoder finished the block.
- mb_done_o  out  1  pulse; last block of the MB is encoded.
- mb_x_o  out  7  current MB column.
- mb_y_o  out  8  current MB row.
- busy_o  out  1  high in every state except IDLE.

## Operation
- **Block coordinates.** bx = {idx[2], idx[0]} and by = {idx[3], idx[1]}.
- **States.**
  - IDLE: wait for frame_start_i.
  - ISSUE: blk_ready_o = cnt_ready_i. cnt_valid_o = blk_valid_i & cnt_ready_i, which is combinational. On handshake, go to COUNT.
  - COUNT: wait for cnt_done_i, then latch total_coeff_i and go to ENCODE.
  - ENCODE: enc_start_o pulses on the first cycle only. Wait for enc_done_i, then write the latched total to cur[idx]. If idx==15 go to MB_END, else idx+1 and go to ISSUE.
  - MB_END: one cycle. Pulse mb_done_o and commit context. Advance position: mb_x+1, or wrap mb_x to 0 and increment mb_y when mb_x == mb_width-1. mb_y wraps 255->0. Set idx to 0, go to ISSUE.
- **cnt_hold_o.** High from the ISSUE handshake until the cycle enc_done_i is seen, otherwise low. The counter's results therefore stay stable during encoding.
- **nC availability.**
  - nA (left) is available if bx>0 or mb_x>0. Source: cur[(bx-1,by)] if bx>0, else left_col[by].
  - nB (top) is available if by>0 or mb_y>0. Source: cur[(bx,by-1)] if by>0, else top_line[mb_x*4+bx].
- **nC value.**
  - Both available: (nA+nB+1)>>1, computed at 6-bit width.
  - One available: that value.
  - Neither available: 0.
- **Commit at MB_END.** left_col[k] = cur[(3,k)] and top_line[mb_x*4+k] = cur[(k,3)], for k = 0..3.
- **frame_start_i.** Accepted in any state; it is an abort. Next cycle: state ISSUE, idx=0, mb_x=mb_y=0, cnt_hold_o low, mb_width latched. Stored context is not cleared, because availability masks it. A stale cnt_done_i or enc_done_i outside COUNT or ENCODE is ignored.
- blk_valid_i outside ISSUE is ignored, and blk_ready_o stays low.

## Timing
- **Reset values.** state IDLE, idx 0, mb_x 0, mb_y 0, and all outputs 0, including enc_nc_o and enc_blk_idx_o.
- **Issue.** cnt_valid_o asserts in the same cycle as the handshake. The state is COUNT on the next edge.
- **Start latency.** The cycle after cnt_done_i is sampled in COUNT: enc_start_o=1, with enc_nc_o and enc_blk_idx_o registered and valid. Both stay stable until the next ENCODE entry.
- **Encode completion.** enc_done_i sampled in ENCODE: next cycle is ISSUE, or MB_END for idx 15.
- **Minimum per-block overhead.** 3 cycles plus counter time plus encoder time, with one extra cycle per MB.
- **Simultaneous events.** frame_start_i wins over every other event in the same cycle. rst wins over frame_start_i.

## Structure
- **Shared package cavlc_pkg:** the state enum; the blk_idx-to-(bx,by) and (bx,by)-to-blk_idx functions; widths TC_W=5 and MB_X_W=7.
- **Sub-module cavlc_nc_ctx_store:** holds cur[16], left_col[4] and top_line[MAX_MB_W*4]. Provides a write port, an MB commit, and a combinational nA/nB lookup with available flags. The scheduler top holds the FSM, counters and nC arithmetic.

## Test plan
- MB (0,0), width 1, all totals 0 → 16 enc_start pulses with nC=0, idx 0..15, then mb_done_o.
- MB (0,0) with TC[0]=3 → block 1 nC=3, since only the left neighbour is available. Block 2 nC=3, since only the top neighbour is available.
- Within an MB, TC[1]=4 and TC[2]=6 → block 3 nC=5.
- Width 2, MB (0,0) with TC[5]=9 → at MB (1,0), block 0 nC=9. MB (0,0) with TC[10]=7 → at MB (0,1), block 0 nC=7, and mb_x wraps to 0.
- blk_valid_i high with cnt_ready_i low → cnt_valid_o and blk_ready_o stay 0. Issue occurs on the first cycle cnt_ready_i rises.
- frame_start_i asserted in ENCODE at idx 7 → next cycle state ISSUE, idx 0, cnt_hold_o 0. A late enc_done_i is ignored. rst asserted mid-COUNT → all outputs 0 and busy_o 0.

Source files
------------

// File: rtl/cavlc_pkg.sv
// Shared definitions for the CAVLC block scheduler slice.
// Provides the scheduler state encoding, datapath widths, and the helpers that
// convert between a 4x4 block index (8x8-then-4x4 order) and its (bx, by)
// coordinates inside the macroblock.
package cavlc_pkg;

  localparam int TC_W   = 5;  // total_coeff width, values 0..16
  localparam int MB_X_W = 7;  // macroblock column width
  localparam int MB_Y_W = 8;  // macroblock row width, wraps 255 -> 0
  localparam int IDX_W  = 4;  // block index within the MB

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_COUNT  = 3'd2,
    ST_ENCODE = 3'd3,
    ST_MB_END = 3'd4
  } state_e;

  // Block column inside the MB: bx = {idx[2], idx[0]}.
  function automatic logic [1:0] blk_bx(input logic [IDX_W-1:0] idx);
    return {idx[2], idx[0]};
  endfunction

  // Block row inside the MB: by = {idx[3], idx[1]}.
  function automatic logic [1:0] blk_by(input logic [IDX_W-1:0] idx);
    return {idx[3], idx[1]};
  endfunction

  // Inverse mapping: (bx, by) back to the 8x8-then-4x4 block index.
  function automatic logic [IDX_W-1:0] blk_idx(input logic [1:0] bx, input logic [1:0] by);
    return {by[1], bx[1], by[0], bx[0]};
  endfunction

endpackage

// File: rtl/cavlc_nc_ctx_store.sv
// Neighbour total-coeff context used to derive nC.
// Holds the totals of the MB being coded (cur), the right-hand column of the
// previous MB in the row (left_col) and the bottom row of every MB in the row
// above (top_line). Lookups are combinational; writes take effect next cycle.
// Ports:
//   clk                 clock
//   wr_en_i/wr_idx_i/wr_tc_i  store one block total into cur
//   commit_i            copy cur's right column to left_col and cur's bottom
//                       row into top_line at the current MB column
//   mb_x_i, mb_y_i      current MB position (commit address and availability)
//   lk_idx_i            block whose neighbours are looked up
//   na_o/na_avail_o     left neighbour total and availability
//   nb_o/nb_avail_o     top neighbour total and availability
module cavlc_nc_ctx_store
  import cavlc_pkg::*;
#(
  parameter int MAX_MB_W = 120
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TC_W-1:0]   wr_tc_i,
  input  logic              commit_i,
  input  logic [MB_X_W-1:0] mb_x_i,
  input  logic [MB_Y_W-1:0] mb_y_i,
  input  logic [IDX_W-1:0]  lk_idx_i,
  output logic [TC_W-1:0]   na_o,
  output logic              na_avail_o,
  output logic [TC_W-1:0]   nb_o,
  output logic              nb_avail_o
);

  localparam int TL_DEPTH = MAX_MB_W * 4;
  localparam int TL_AW    = $clog2(TL_DEPTH);

  logic [TC_W-1:0]  cur_q        [16];
  logic [TC_W-1:0]  cur_d        [16];
  logic [TC_W-1:0]  left_col_q   [4];
  logic [TC_W-1:0]  left_col_d   [4];
  logic [TC_W-1:0]  top_line_mem [TL_DEPTH];

  logic [TL_AW-1:0] tl_base_s;
  logic [TL_AW-1:0] tl_rd_addr_s;
  logic [1:0]       lk_bx_s;
  logic [1:0]       lk_by_s;

  // top_line entry of block column bx in MB column x is x*4+bx.
  assign tl_base_s = TL_AW'({mb_x_i, 2'b00});

  // Next-value logic for the current-MB totals and the left column.
  always_comb begin
    cur_d      = cur_q;
    left_col_d = left_col_q;
    if (wr_en_i) begin
      cur_d[wr_idx_i] = wr_tc_i;
    end else begin
      cur_d = cur_q;
    end
    if (commit_i) begin
      for (int k = 0; k < 4; k++) begin
        left_col_d[k] = cur_q[blk_idx(2'd3, 2'(k))];
      end
    end else begin
      left_col_d = left_col_q;
    end
  end

  // Context registers; availability masks any stale content, so no reset.
  always_ff @(posedge clk) begin
    cur_q      <= cur_d;
    left_col_q <= left_col_d;
  end

  // Line store write: bottom row of the finished MB at its column slot.
  always_ff @(posedge clk) begin
    if (commit_i) begin
      for (int k = 0; k < 4; k++) begin
        top_line_mem[tl_base_s + TL_AW'(k)] <= cur_q[blk_idx(2'(k), 2'd3)];
      end
    end
  end

  // Neighbour lookup: inside the MB use cur, across the MB edge use the
  // left column or the line store.
  always_comb begin
    lk_bx_s      = blk_bx(lk_idx_i);
    lk_by_s      = blk_by(lk_idx_i);
    tl_rd_addr_s = TL_AW'({mb_x_i, lk_bx_s});
    na_avail_o   = (lk_bx_s != 2'd0) || (mb_x_i != 7'd0);
    nb_avail_o   = (lk_by_s != 2'd0) || (mb_y_i != 8'd0);
    if (lk_bx_s != 2'd0) begin
      na_o = cur_q[blk_idx(lk_bx_s - 2'd1, lk_by_s)];
    end else begin
      na_o = left_col_q[lk_by_s];
    end
    if (lk_by_s != 2'd0) begin
      nb_o = cur_q[blk_idx(lk_bx_s, lk_by_s - 2'd1)];
    end else begin
      nb_o = top_line_mem[tl_rd_addr_s];
    end
  end

endmodule

// File: rtl/cavlc_blk_scheduler.sv
// Sequences the 16 luma 4x4 blocks of each MB through the CAVLC counter and
// the CAVLC bitstream encoder, tracks MB position and produces nC per block.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   frame_start_i       restart at MB (0,0) from any state, latches mb_width_i
//   mb_width_i          picture width in MBs
//   blk_valid_i/blk_ready_o   block handshake with the coefficient source
//   cnt_valid_o/cnt_ready_i   issue into the counter (combinational)
//   cnt_done_i, total_coeff_i counter result
//   cnt_hold_o          keeps the counter parked while its result is encoded
//   enc_start_o, enc_nc_o, enc_blk_idx_o, enc_done_i  encoder control
//   mb_done_o           pulse when the last block of an MB is encoded
//   mb_x_o, mb_y_o      current MB position
//   busy_o              high whenever the FSM is not idle
module cavlc_blk_scheduler
  import cavlc_pkg::*;
#(
  parameter int MAX_MB_W = 120
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start_i,
  input  logic [MB_X_W-1:0] mb_width_i,
  input  logic              blk_valid_i,
  output logic              blk_ready_o,
  output logic              cnt_valid_o,
  input  logic              cnt_ready_i,
  input  logic              cnt_done_i,
  input  logic [TC_W-1:0]   total_coeff_i,
  output logic              cnt_hold_o,
  output logic              enc_start_o,
  output logic [TC_W-1:0]   enc_nc_o,
  output logic [IDX_W-1:0]  enc_blk_idx_o,
  input  logic              enc_done_i,
  output logic              mb_done_o,
  output logic [MB_X_W-1:0] mb_x_o,
  output logic [MB_Y_W-1:0] mb_y_o,
  output logic              busy_o
);

  state_e            state_q,       state_d;
  logic [IDX_W-1:0]  idx_q,         idx_d;
  logic [MB_X_W-1:0] mb_x_q,        mb_x_d;
  logic [MB_Y_W-1:0] mb_y_q,        mb_y_d;
  logic [MB_X_W-1:0] mb_width_q,    mb_width_d;
  logic [TC_W-1:0]   tc_q,          tc_d;
  logic              hold_q,        hold_d;
  logic              enc_start_q,   enc_start_d;
  logic [TC_W-1:0]   enc_nc_q,      enc_nc_d;
  logic [IDX_W-1:0]  enc_blk_idx_q, enc_blk_idx_d;

  logic              ctx_wr_s;
  logic              ctx_commit_s;
  logic [TC_W-1:0]   na_s;
  logic              na_avail_s;
  logic [TC_W-1:0]   nb_s;
  logic              nb_avail_s;
  logic [5:0]        nc_sum_s;
  logic [TC_W-1:0]   nc_s;
  logic              last_col_s;

  cavlc_nc_ctx_store #(
    .MAX_MB_W (MAX_MB_W)
  ) u_ctx (
    .clk        (clk),
    .wr_en_i    (ctx_wr_s),
    .wr_idx_i   (idx_q),
    .wr_tc_i    (tc_q),
    .commit_i   (ctx_commit_s),
    .mb_x_i     (mb_x_q),
    .mb_y_i     (mb_y_q),
    .lk_idx_i   (idx_q),
    .na_o       (na_s),
    .na_avail_o (na_avail_s),
    .nb_o       (nb_s),
    .nb_avail_o (nb_avail_s)
  );

  assign last_col_s = (mb_x_q == (mb_width_q - 7'd1));

  // nC: rounded average when both neighbours exist, else the one that does.
  always_comb begin
    nc_sum_s = {1'b0, na_s} + {1'b0, nb_s} + 6'd1;
    case ({na_avail_s, nb_avail_s})
      2'b11:   nc_s = nc_sum_s[5:1];
      2'b10:   nc_s = na_s;
      2'b01:   nc_s = nb_s;
      default: nc_s = 5'd0;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= 4'd0;
      mb_x_q        <= 7'd0;
      mb_y_q        <= 8'd0;
      mb_width_q    <= 7'd0;
      tc_q          <= 5'd0;
      hold_q        <= 1'b0;
      enc_start_q   <= 1'b0;
      enc_nc_q      <= 5'd0;
      enc_blk_idx_q <= 4'd0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      mb_x_q        <= mb_x_d;
      mb_y_q        <= mb_y_d;
      mb_width_q    <= mb_width_d;
      tc_q          <= tc_d;
      hold_q        <= hold_d;
      enc_start_q   <= enc_start_d;
      enc_nc_q      <= enc_nc_d;
      enc_blk_idx_q <= enc_blk_idx_d;
    end
  end

  // Next-state and datapath update; frame_start_i overrides every state.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    mb_x_d        = mb_x_q;
    mb_y_d        = mb_y_q;
    mb_width_d    = mb_width_q;
    tc_d          = tc_q;
    hold_d        = hold_q;
    enc_start_d   = 1'b0;
    enc_nc_d      = enc_nc_q;
    enc_blk_idx_d = enc_blk_idx_q;
    ctx_wr_s      = 1'b0;
    ctx_commit_s  = 1'b0;
    if (frame_start_i) begin
      state_d    = ST_ISSUE;
      idx_d      = 4'd0;
      mb_x_d     = 7'd0;
      mb_y_d     = 8'd0;
      mb_width_d = mb_width_i;
      hold_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_ISSUE: begin
          if (cnt_valid_o) begin
            state_d = ST_COUNT;
            hold_d  = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end
        ST_COUNT: begin
          if (cnt_done_i) begin
            state_d       = ST_ENCODE;
            tc_d          = total_coeff_i;
            enc_start_d   = 1'b1;
            enc_nc_d      = nc_s;
            enc_blk_idx_d = idx_q;
          end else begin
            state_d = ST_COUNT;
          end
        end
        ST_ENCODE: begin
          if (enc_done_i) begin
            ctx_wr_s = 1'b1;
            hold_d   = 1'b0;
            if (idx_q == 4'd15) begin
              state_d = ST_MB_END;
            end else begin
              idx_d   = idx_q + 4'd1;
              state_d = ST_ISSUE;
            end
          end else begin
            state_d = ST_ENCODE;
          end
        end
        ST_MB_END: begin
          ctx_commit_s = 1'b1;
          idx_d        = 4'd0;
          state_d      = ST_ISSUE;
          if (last_col_s) begin
            mb_x_d = 7'd0;
            mb_y_d = mb_y_q + 8'd1;
          end else begin
            mb_x_d = mb_x_q + 7'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State-decoded outputs. Issue is suppressed while a restart is pending so
  // the counter never starts a block the scheduler is about to drop.
  always_comb begin
    blk_ready_o = 1'b0;
    cnt_valid_o = 1'b0;
    mb_done_o   = 1'b0;
    busy_o      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
      end
      ST_ISSUE: begin
        blk_ready_o = cnt_ready_i & ~frame_start_i;
        cnt_valid_o = blk_valid_i & cnt_ready_i & ~frame_start_i;
      end
      ST_MB_END: begin
        mb_done_o = 1'b1;
      end
      default: begin
        busy_o = 1'b1;
      end
    endcase
  end

  assign cnt_hold_o    = hold_q;
  assign enc_start_o   = enc_start_q;
  assign enc_nc_o      = enc_nc_q;
  assign enc_blk_idx_o = enc_blk_idx_q;
  assign mb_x_o        = mb_x_q;
  assign mb_y_o        = mb_y_q;

endmodule
